// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter. A word is accepted over a
// valid/ready handshake and shifted out on SDO. SEN strobes once per bit
// so that a serial-in shift register can capture the word.
module serial_word_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PDATA,
    input  logic             PVALID,
    output logic             PREADY,
    input  logic             STALL,
    output logic             SDO,
    output logic             SEN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] bitcnt;
    logic             strobe_cond;

    // Bit currently presented at the serial output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] r);
        if (MSB_FIRST)
            return r[WIDTH-1];
        else
            return r[0];
    endfunction

    // Advance the shift register one bit toward the output end, zero fill.
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] r);
        if (MSB_FIRST)
            return {r[WIDTH-2:0], 1'b0};
        else
            return {1'b0, r[WIDTH-1:1]};
    endfunction

    // Output decode: everything from registers, only SEN is gated by STALL.
    always_comb begin
        strobe_cond = (state == ST_SHIFT) && (div == DIV_LAST);
        SEN         = strobe_cond & ~STALL;
        SDO         = (state == ST_SHIFT) ? out_bit(shreg) : 1'b0;
        PREADY      = (state == ST_IDLE);
        BUSY        = (state == ST_SHIFT) || (state == ST_DONE);
        DONE        = (state == ST_DONE);
    end

    // Frame sequencer: accept, divide, shift, count bits, single-cycle DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            div    <= '0;
            bitcnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PVALID) begin
                        shreg  <= PDATA;
                        div    <= '0;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!STALL) begin
                        if (div == DIV_LAST) begin
                            div    <= '0;
                            shreg  <= shift_next(shreg);
                            bitcnt <= bitcnt + CNT_W'(1);
                            if (bitcnt == CNT_LAST)
                                state <= ST_DONE;
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: an 8-bit receiver model fed by SDO/SEN, a
// scoreboard of expected bits and words, and per-scenario timing tasks.
module tb_serial_word_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] PDATA = 8'h55;
    logic       PVALID = 1'b1;
    logic       STALL = 1'b0;
    logic       PREADY, SDO, SEN, BUSY, DONE;

    logic [7:0] pdata1 = 8'h00;
    logic       pvalid1 = 1'b0;
    logic       stall1 = 1'b0;
    logic       pready1, sdo1, sen1, busy1, done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx = 8'h00;
    logic       bitq[$];
    logic [7:0] wordq[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    serial_word_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut (
        .CLK(CLK), .RST(RST), .PDATA(PDATA), .PVALID(PVALID), .PREADY(PREADY),
        .STALL(STALL), .SDO(SDO), .SEN(SEN), .BUSY(BUSY), .DONE(DONE)
    );

    serial_word_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .PDATA(pdata1), .PVALID(pvalid1), .PREADY(pready1),
        .STALL(stall1), .SDO(sdo1), .SEN(sen1), .BUSY(busy1), .DONE(done1)
    );

    // Receiver model and scoreboard, sampled mid-cycle on the main instance.
    always @(negedge CLK) begin
        if (RST) begin
            bitq.delete();
            wordq.delete();
        end else begin
            if (SEN) begin
                checks++;
                if (bitq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_bit: unexpected strobe, SDO=%b, no bit expected", SDO);
                end else begin
                    logic eb;
                    eb = bitq.pop_front();
                    if (SDO !== eb) begin
                        errors++;
                        $display("FAIL sb_bit: SDO=%b expected %b at cycle %0d", SDO, eb, cyc);
                    end
                end
                rx = {rx[6:0], SDO};
            end
            if (DONE) begin
                checks++;
                if (wordq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_word: unexpected DONE, rx=%h, no word expected", rx);
                end else begin
                    logic [7:0] ew;
                    ew = wordq.pop_front();
                    if (rx !== ew) begin
                        errors++;
                        $display("FAIL sb_word: received %h expected %h", rx, ew);
                    end
                end
            end
            if (PVALID && PREADY) begin
                wordq.push_back(PDATA);
                for (int i = 7; i >= 0; i--) bitq.push_back(PDATA[i]);
            end
        end
    end

    // Present a word and return just after its accept edge (e0 = that edge).
    task automatic send(input logic [7:0] w, input bit hold, output int e0);
        bit rdy, got;
        got = 1'b0;
        e0 = 0;
        @(posedge CLK); #1;
        PDATA = w;
        PVALID = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge CLK);
            rdy = PREADY;
            @(posedge CLK); #1;
            if (rdy) got = 1'b1;
        end
        e0 = cyc;
        if (!hold) PVALID = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted, PREADY=%b required 1", w, PREADY);
        end
    endtask

    // Wait (bounded) for DONE; returns the edge that raised it.
    task automatic wait_done(output int d);
        bit found;
        found = 1'b0;
        d = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            if (DONE) begin
                found = 1'b1;
                d = cyc;
            end else begin
                @(posedge CLK); #1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: DONE=%b required 1 within 200 cycles", DONE);
        end
    endtask

    task automatic test_reset;
        int e0;
        logic [4:0] act;
        repeat (3) begin @(posedge CLK); #1; end
        act = {SDO, SEN, BUSY, DONE, PREADY};
        checks++;
        if (act !== 5'b00001) begin
            errors++;
            $display("FAIL reset_hold: {sdo,sen,busy,done,pready}=%b required 00001", act);
        end
        PVALID = 1'b0;
        RST = 1'b0;
        send(8'h5A, 1'b0, e0);
        repeat (6) begin @(posedge CLK); #1; end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL reset_prebusy: BUSY=%b required 1", BUSY);
        end
        #2;
        RST = 1'b1;
        #1;
        act = {SDO, SEN, BUSY, DONE, PREADY};
        checks++;
        if (act !== 5'b00001) begin
            errors++;
            $display("FAIL reset_async: {sdo,sen,busy,done,pready}=%b required 00001", act);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        act = {SDO, SEN, BUSY, DONE, PREADY};
        checks++;
        if (act !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release: {sdo,sen,busy,done,pready}=%b required 00001", act);
        end
    endtask

    task automatic test_send_a5;
        int e0;
        logic [7:0] w;
        logic [4:0] exp, act;
        w = 8'hA5;
        send(w, 1'b0, e0);
        for (int k = 0; k < 34; k++) begin
            exp[4] = (k < 32) ? w[7 - k / 4] : 1'b0;
            exp[3] = (k < 32) && (k % 4 == 3);
            exp[2] = (k < 33);
            exp[1] = (k == 32);
            exp[0] = (k == 33);
            act = {SDO, SEN, BUSY, DONE, PREADY};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL a5_timing E0+%0d: {sdo,sen,busy,done,pready}=%b required %b", k, act, exp);
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (rx !== 8'hA5) begin
            errors++;
            $display("FAIL a5_rx: received %h required a5", rx);
        end
    endtask

    task automatic test_back_to_back;
        int e0, d;
        bit rdy, got;
        int acc;
        got = 1'b0;
        acc = -1;
        send(8'h3C, 1'b1, e0);
        PDATA = 8'hC3;
        for (int i = 0; i < 60 && !got; i++) begin
            if (cyc == e0 + 5) PDATA = 8'h00;
            if (cyc == e0 + 20) PDATA = 8'hC3;
            @(negedge CLK);
            rdy = PREADY;
            @(posedge CLK); #1;
            if (rdy) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        PVALID = 1'b0;
        checks++;
        if (acc !== e0 + 34) begin
            errors++;
            $display("FAIL b2b_accept: second accept at E0+%0d required E0+34", acc - e0);
        end
        wait_done(d);
        checks++;
        if (d - acc !== 32) begin
            errors++;
            $display("FAIL b2b_done: DONE at accept+%0d required accept+32", d - acc);
        end
        checks++;
        if (rx !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_rx: received %h required c3", rx);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_stall;
        int e0, d;
        logic [1:0] act;
        send(8'h96, 1'b0, e0);
        repeat (12) begin @(posedge CLK); #1; end
        STALL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            act = {SEN, SDO};
            checks++;
            if (act !== 2'b01) begin
                errors++;
                $display("FAIL stall_freeze cycle %0d: {sen,sdo}=%b required 01", i, act);
            end
            @(posedge CLK); #1;
        end
        STALL = 1'b0;
        wait_done(d);
        checks++;
        if (d - e0 !== 37) begin
            errors++;
            $display("FAIL stall_done: DONE at E0+%0d required E0+37", d - e0);
        end
        checks++;
        if (rx !== 8'h96) begin
            errors++;
            $display("FAIL stall_rx: received %h required 96", rx);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_abort;
        int e0, d, ndone;
        logic [4:0] act;
        send(8'hF0, 1'b0, e0);
        repeat (20) begin @(posedge CLK); #1; end
        #2;
        RST = 1'b1;
        #1;
        act = {SDO, SEN, BUSY, DONE, PREADY};
        checks++;
        if (act !== 5'b00001) begin
            errors++;
            $display("FAIL abort_outputs: {sdo,sen,busy,done,pready}=%b required 00001", act);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_nodone: %0d DONE pulses required 0", ndone);
        end
        send(8'hFF, 1'b0, e0);
        wait_done(d);
        checks++;
        if (d - e0 !== 32) begin
            errors++;
            $display("FAIL abort_next_done: DONE at E0+%0d required E0+32", d - e0);
        end
        checks++;
        if (rx !== 8'hFF) begin
            errors++;
            $display("FAIL abort_rx: received %h required ff", rx);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_div1_lsb;
        int e0;
        logic [7:0] w;
        logic [4:0] exp, act;
        w = 8'h01;
        @(posedge CLK); #1;
        checks++;
        if (pready1 !== 1'b1) begin
            errors++;
            $display("FAIL div1_ready: PREADY=%b required 1", pready1);
        end
        pdata1 = w;
        pvalid1 = 1'b1;
        @(posedge CLK); #1;
        e0 = cyc;
        pvalid1 = 1'b0;
        pdata1 = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            exp[4] = (k < 8) ? w[k] : 1'b0;
            exp[3] = (k < 8);
            exp[2] = (k < 9);
            exp[1] = (k == 8);
            exp[0] = (k == 9);
            act = {sdo1, sen1, busy1, done1, pready1};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL div1_timing E0+%0d: {sdo,sen,busy,done,pready}=%b required %b", cyc - e0, act, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_send_a5();
        test_back_to_back();
        test_stall();
        test_abort();
        test_div1_lsb();
        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
